// File: rtl/jtbubl_rom_slot_if.sv
// Graphics ROM slot bus: client request side (slot_*) and SDRAM arbiter side
// (sdram_*, data_*) of one ROM slot.
//   slave  : the slot itself (jtbubl_rom_slot)
//   master : whatever drives requests and answers bursts (client + arbiter)
// Signals:
//   slot_cs/slot_addr  -> request enable and 32-bit word address
//   slot_dout/slot_ok  <- assembled read data and its valid flag
//   sdram_addr/req     <- 16-bit word address and burst request
//   sdram_ack          -> request accepted (1-cycle pulse)
//   data_rdy/data_read -> one 16-bit beat
interface jtbubl_rom_slot_if #(
  parameter int unsigned AW = 18
);
  logic          slot_cs;
  logic [AW-1:0] slot_addr;
  logic [31:0]   slot_dout;
  logic          slot_ok;
  logic [21:0]   sdram_addr;
  logic          sdram_req;
  logic          sdram_ack;
  logic          data_rdy;
  logic [15:0]   data_read;

  modport slave (
    input  slot_cs, slot_addr, sdram_ack, data_rdy, data_read,
    output slot_dout, slot_ok, sdram_addr, sdram_req
  );

  modport master (
    output slot_cs, slot_addr, sdram_ack, data_rdy, data_read,
    input  slot_dout, slot_ok, sdram_addr, sdram_req
  );
endinterface

// File: rtl/jtbubl_rom_slot.sv
// Responder end of a graphics ROM client port. Each 32-bit client read becomes
// a two-beat 16-bit SDRAM burst (low half first); the assembled word is held on
// slot_dout with slot_ok while the client keeps the same address selected.
// Ports:
//   rst  asynchronous reset, active high
//   clk  system clock
//   bus  jtbubl_rom_slot_if.slave (slot_* client side, sdram_*/data_* arbiter side)
// Parameters:
//   AW      client word-address width
//   OFFSET  16-bit-word base of this client's region in SDRAM
// Optional feature:
//   JTBUBL_ROMSLOT_CACHE_EN  one-entry tag of the last completed address; a
//   request matching it is answered next cycle without an SDRAM burst.
module jtbubl_rom_slot #(
  parameter int unsigned AW     = 18,
  parameter logic [21:0] OFFSET = 22'h0
) (
  input  logic               rst,
  input  logic               clk,
  jtbubl_rom_slot_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, REQ, BEAT0, BEAT1} state_t;

  state_t        state, state_next;
  logic [AW-1:0] addr_lat;
  logic [31:0]   dout;
  logic [21:0]   sdram_addr;
  logic          sdram_req;
  logic          ok_reg;
  logic          stale;
  logic          addr_match, cs_match;
  logic          cache_hit;
  logic          start, hit_load, lo_wr, hi_wr;

  assign addr_match     = bus.slot_addr == addr_lat;
  assign cs_match       = bus.slot_cs && addr_match;
  assign bus.slot_ok    = ok_reg && cs_match;
  assign bus.slot_dout  = dout;
  assign bus.sdram_addr = sdram_addr;
  assign bus.sdram_req  = sdram_req;

`ifdef JTBUBL_ROMSLOT_CACHE_EN
  logic [AW-1:0] tag;
  logic          tag_valid;

  assign cache_hit = tag_valid && (bus.slot_addr == tag);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag       <= '0;
      tag_valid <= 1'b0;
    end else if (hi_wr) begin
      tag       <= addr_lat;
      tag_valid <= 1'b1;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    hit_load   = 1'b0;
    lo_wr      = 1'b0;
    hi_wr      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.slot_cs && !(ok_reg && addr_match)) begin
          if (cache_hit) begin
            hit_load = 1'b1;
          end else begin
            start      = 1'b1;
            state_next = REQ;
          end
        end
      end
      REQ: begin
        // A beat arriving with the ack is the first beat of the burst
        if (bus.sdram_ack) begin
          lo_wr      = bus.data_rdy;
          state_next = bus.data_rdy ? BEAT1 : BEAT0;
        end
      end
      BEAT0: begin
        if (bus.data_rdy) begin
          lo_wr      = 1'b1;
          state_next = BEAT1;
        end
      end
      BEAT1: begin
        if (bus.data_rdy) begin
          hi_wr      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_lat   <= '0;
      dout       <= '0;
      sdram_addr <= '0;
      sdram_req  <= 1'b0;
      ok_reg     <= 1'b0;
      stale      <= 1'b0;
    end else begin
      if (start) begin
        addr_lat   <= bus.slot_addr;
        sdram_req  <= 1'b1;
        sdram_addr <= OFFSET + 22'({bus.slot_addr, 1'b0});
        stale      <= 1'b0;
      end else if (hit_load) begin
        addr_lat <= bus.slot_addr;
      end
      if (state == REQ && bus.sdram_ack) sdram_req <= 1'b0;
      if (lo_wr) begin
        dout[15:0] <= bus.data_read;
        sdram_addr <= OFFSET + 22'({addr_lat, 1'b1});
      end
      if (hi_wr) dout[31:16] <= bus.data_read;
      // Any deselect or address change during a burst forfeits its slot_ok,
      // even if the client comes back to the same address before completion.
      if (state != IDLE && !cs_match) stale <= 1'b1;
      if (hi_wr)               ok_reg <= !stale && cs_match;
      else if (hit_load)       ok_reg <= 1'b1;
      else if (start || !cs_match) ok_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtbubl_rom_slot.sv
module tb_jtbubl_rom_slot;

  localparam logic [21:0] OFF = 22'h10000;

  logic clk;
  logic rst;
  int   total;
  int   passed;

  jtbubl_rom_slot_if #(.AW(18)) bus ();

  jtbubl_rom_slot #(.AW(18), .OFFSET(OFF)) dut (
    .rst (rst),
    .clk (clk),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (observed running, required done)");
    $fatal(1, "watchdog");
  end

  // Reference address map: 16-bit word = OFFSET + 2*addr + beat, modulo 2^22
  function automatic logic [21:0] exp_addr(input logic [17:0] a, input int unsigned beat);
    longint s;
    s = longint'(OFF) + 2 * longint'(a) + longint'(beat);
    return 22'(s % 64'd4194304);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Plays client + arbiter for one burst of address a. After the ack the client
  // moves to (mid_cs, mid_a); slot_ok is expected only if it stayed put.
  task automatic serve(input logic [17:0] a, input int w, input int g0, input int g1,
                       input bit same, input logic mid_cs, input logic [17:0] mid_a,
                       input logic [15:0] lo, input logic [15:0] hi);
    int n;
    bus.slot_cs   = 1'b1;
    bus.slot_addr = a;
    n = 0;
    while (bus.sdram_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("req_rise", bus.sdram_req, 1);
    chk("addr_beat0", bus.sdram_addr, exp_addr(a, 0));
    chk("ok_low_req", bus.slot_ok, 0);
    for (int i = 0; i < w; i++) begin
      tick();
      chk("stall_req", bus.sdram_req, 1);
      chk("stall_addr", bus.sdram_addr, exp_addr(a, 0));
      chk("stall_ok", bus.slot_ok, 0);
    end
    bus.sdram_ack = 1'b1;
    if (same) begin
      bus.data_rdy  = 1'b1;
      bus.data_read = lo;
    end
    tick();
    bus.sdram_ack = 1'b0;
    bus.data_rdy  = 1'b0;
    bus.data_read = 16'($urandom);
    bus.slot_cs   = mid_cs;
    bus.slot_addr = mid_a;
    chk("req_drop", bus.sdram_req, 0);
    if (!same) begin
      repeat (g0) tick();
      bus.data_rdy  = 1'b1;
      bus.data_read = lo;
      tick();
      bus.data_rdy  = 1'b0;
    end
    chk("addr_beat1", bus.sdram_addr, exp_addr(a, 1));
    chk("ok_mid", bus.slot_ok, 0);
    repeat (g1) tick();
    bus.data_rdy  = 1'b1;
    bus.data_read = hi;
    tick();
    bus.data_rdy  = 1'b0;
    chk("dout", bus.slot_dout, {hi, lo});
    chk("ok_done", bus.slot_ok, (mid_cs && mid_a == a) ? 1 : 0);
  endtask

  initial begin
    logic [17:0] a, prev, mid_a;
    logic [31:0] held;
    logic        mid_cs;
    bit          exp_ok;

    total = 0;
    passed = 0;
    prev = '0;
    rst = 1'b1;
    bus.slot_cs   = 1'b0;
    bus.slot_addr = '0;
    bus.sdram_ack = 1'b0;
    bus.data_rdy  = 1'b0;
    bus.data_read = '0;
    tick();
    tick();
    chk("rst_ok", bus.slot_ok, 0);
    chk("rst_dout", bus.slot_dout, 0);
    chk("rst_req", bus.sdram_req, 0);
    chk("rst_addr", bus.sdram_addr, 0);
    rst = 1'b0;
    tick();
    tick();
    chk("idle_no_req", bus.sdram_req, 0);

    // Basic miss
    serve(18'h00010, 0, 0, 0, 0, 1'b1, 18'h00010, 16'hBEEF, 16'hDEAD);
    chk("basic_addr1", bus.sdram_addr, 22'h10021);
    chk("basic_dout", bus.slot_dout, 32'hDEADBEEF);
    repeat (4) begin
      tick();
      chk("hold_ok", bus.slot_ok, 1);
      chk("hold_no_req", bus.sdram_req, 0);
    end

    // Stray beats while idle
    repeat (3) begin
      bus.data_rdy  = 1'b1;
      bus.data_read = 16'($urandom);
      tick();
      bus.data_rdy  = 1'b0;
      chk("stray_dout", bus.slot_dout, 32'hDEADBEEF);
      chk("stray_ok", bus.slot_ok, 1);
      chk("stray_req", bus.sdram_req, 0);
    end

    // Arbiter stall of 20 cycles
    serve(18'h01234, 20, 1, 2, 0, 1'b1, 18'h01234, 16'($urandom), 16'($urandom));

    // Address change mid-burst, then refetch of the new address
    serve(18'h00001, 1, 0, 0, 0, 1'b1, 18'h00002, 16'h1111, 16'h2222);
    serve(18'h00002, 0, 0, 1, 0, 1'b1, 18'h00002, 16'h3333, 16'h4444);
    chk("chg_addr1", bus.sdram_addr, OFF + 22'h5);

    // Deselect mid-burst: no ok, no further request
    serve(18'h00777, 2, 1, 0, 0, 1'b0, 18'h00777, 16'($urandom), 16'($urandom));
    repeat (3) begin
      tick();
      chk("cs0_no_req", bus.sdram_req, 0);
      chk("cs0_ok", bus.slot_ok, 0);
    end

    // Ack and first beat in the same cycle
    serve(18'h2ABCD, 3, 0, 1, 1, 1'b1, 18'h2ABCD, 16'($urandom), 16'($urandom));

    // Top address, then 0, then leave and return to 0
    serve(18'h3FFFF, 0, 0, 0, 0, 1'b1, 18'h3FFFF, 16'($urandom), 16'($urandom));
    serve(18'h00000, 1, 0, 0, 0, 1'b1, 18'h00000, 16'hCAFE, 16'hF00D);
    bus.slot_cs = 1'b0;
    tick();
    chk("leave_ok", bus.slot_ok, 0);
    bus.slot_cs = 1'b1;
    tick();
`ifdef JTBUBL_ROMSLOT_CACHE_EN
    chk("hit_ok", bus.slot_ok, 1);
    chk("hit_no_req", bus.sdram_req, 0);
    repeat (3) begin
      tick();
      chk("hit_hold_ok", bus.slot_ok, 1);
      chk("hit_hold_req", bus.sdram_req, 0);
    end
    chk("hit_dout", bus.slot_dout, 32'hF00DCAFE);
`else
    chk("refetch_req", bus.sdram_req, 1);
    chk("refetch_ok", bus.slot_ok, 0);
    serve(18'h00000, 0, 0, 0, 0, 1'b1, 18'h00000, 16'h5A5A, 16'hA5A5);
`endif

    // Asynchronous reset during the first beat wait
    bus.slot_cs   = 1'b1;
    bus.slot_addr = 18'h00123;
    tick();
    chk("pre_rst_req", bus.sdram_req, 1);
    bus.sdram_ack = 1'b1;
    tick();
    bus.sdram_ack = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_ok", bus.slot_ok, 0);
    chk("arst_req", bus.sdram_req, 0);
    chk("arst_dout", bus.slot_dout, 0);
    chk("arst_addr", bus.sdram_addr, 0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    serve(18'h00123, 0, 0, 0, 0, 1'b1, 18'h00123, 16'($urandom), 16'($urandom));
    prev = 18'h00123;

    // Randomized bursts
    for (int it = 0; it < 30; it++) begin
      do a = 18'($urandom); while (a == prev);
      mid_cs = 1'b1;
      mid_a  = a;
      if ($urandom_range(0, 3) == 0) begin
        mid_cs = 1'($urandom_range(0, 1));
        mid_a  = 18'($urandom);
      end
      exp_ok = mid_cs && (mid_a == a);
      serve(a, $urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 7) == 0, mid_cs, mid_a, 16'($urandom), 16'($urandom));
      if (exp_ok) begin
        held = bus.slot_dout;
        tick();
        chk("rnd_hold_ok", bus.slot_ok, 1);
        chk("rnd_hold_req", bus.sdram_req, 0);
      end
      prev = a;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
